// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// The FSM state encoding and the default requester count / watchdog limit
// live here so the top level and any wrapper agree on them.
package uart_arb_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 2048;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin selector: finds the first set request at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] index,
  output logic         any
);

  logic [W:0]   sum;
  logic [W-1:0] cand;

  // Scan from the farthest offset down to zero so the nearest request to ptr wins
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (W + 1)'(k);
      if (sum >= (W + 1)'(N)) begin
        sum = sum - (W + 1)'(N);
      end
      cand = sum[W-1:0];
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        index       = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single bytes from NUM_REQ requesters into one
// UART transmitter. One byte is accepted per transfer; the FSM tracks the
// transmitter's busy handshake before accepting the next byte.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a transfer whose
// busy handshake stalls for TIMEOUT_CYCLES cycles (pulses err_timeout).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic               accept;
  logic               timeout_hit;
  logic [7:0]         tx_data_reg;
  logic [IDX_W-1:0]   grant_id_reg;
  logic               tx_start_reg;
  logic [7:0]         req_byte [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  rr_picker #(.N(NUM_REQ), .W(IDX_W)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (pick_grant),
    .index (pick_idx),
    .any   (pick_any)
  );

  // Accept only from IDLE with the transmitter free; reset also blocks it so
  // req_ready is zero while reset_n is low.
  assign accept      = reset_n & (state_reg == IDLE) & ~tx_busy & pick_any;
  assign rr_ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wd_cnt_reg;
  logic             err_timeout_reg;

  assign timeout_hit = ((state_reg == WAIT_BUSY) || (state_reg == WAIT_DONE)) &&
                       (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent waiting on the transmitter, restarts otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_reg      <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      err_timeout_reg <= timeout_hit;
      if (((state_reg == WAIT_BUSY) || (state_reg == WAIT_DONE)) && !timeout_hit) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end else begin
        wd_cnt_reg <= '0;
      end
    end
  end

  assign err_timeout = err_timeout_reg;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a watchdog expiry overrides the normal handshake
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (accept)   state_next = ISSUE;
      ISSUE:                   state_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
    if (timeout_hit) begin
      state_next = IDLE;
    end
  end

  // Capture the winning byte, owner and pointer on accept; start pulse follows
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg   <= '0;
      tx_data_reg  <= '0;
      grant_id_reg <= '0;
      tx_start_reg <= 1'b0;
    end else begin
      tx_start_reg <= accept;
      if (accept) begin
        rr_ptr_reg   <= rr_ptr_next;
        tx_data_reg  <= req_byte[pick_idx];
        grant_id_reg <= pick_idx;
      end
    end
  end

  // Output decode: ready strobe for the winner only when an accept is possible
  always_comb begin
    req_ready = '0;
    arb_busy  = (state_reg != IDLE);
    if (accept) begin
      req_ready = pick_grant;
    end
  end

  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (four requesters). A behavioural
// transmitter raises tx_busy one cycle after tx_start for busy_len cycles,
// or holds tx_busy at a forced level.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 2048;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;

  bit   busy_force = 1'b0;
  logic busy_val   = 1'b0;
  int   busy_len   = 20;
  int   busy_left  = 0;
  bit   pending    = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Transmitter model, updated on the falling edge
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pending   = 1'b0;
        busy_left = 0;
        if (!busy_force) tx_busy = 1'b0;
      end
      if (busy_force) begin
        tx_busy = busy_val;
      end else if (reset_n) begin
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) tx_busy = 1'b0;
        end
        if (pending) begin
          tx_busy   = 1'b1;
          busy_left = busy_len;
          pending   = 1'b0;
        end
        if (tx_start) pending = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got stuck want finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!arb_busy && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    req_valid = 4'b0000;
    reset_n   = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    repeat (2) tick();
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    tests++; if (arb_busy !== 1'b0) begin fails++; $display("FAIL reset_arb_busy: got %b want 0", arb_busy); end
    tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
    req_valid = 4'b0000;
    reset_n   = 1'b1;
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    bit seen = 1'b0, done = 1'b0, hold_ok = 1'b1;
    busy_len  = 20;
    req_data  = 32'h44A5_2211;
    req_valid = 4'b0100;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL single_tx_start: got %b want 1", tx_start); end
    tests++; if (tx_data !== 8'hA5) begin fails++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
    tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
    tests++; if (arb_busy !== 1'b1) begin fails++; $display("FAIL single_arb_busy: got %b want 1", arb_busy); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL single_ready_issue: got %b want 0000", req_ready); end
    tick();
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_start_pulse: got %b want 0", tx_start); end
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_busy) seen = 1'b1;
      if (tx_busy && (!arb_busy || tx_data !== 8'hA5)) hold_ok = 1'b0;
      if (seen && !tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    tests++; if (!done) begin fails++; $display("FAIL single_busy_cycle: got no busy pulse want busy rise and fall"); end
    tests++; if (!hold_ok) begin fails++; $display("FAIL single_hold: got arb_busy/tx_data changed want stable while busy"); end
    tests++; if (arb_busy !== 1'b0) begin fails++; $display("FAIL single_arb_fall: got %b want 0", arb_busy); end
    $display("[TB] test_single done");
  endtask

  task automatic test_round_robin();
    logic [7:0] bytes [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    logic [3:0] expv;
    bit found, ok;
    apply_reset();
    busy_len  = 2;
    req_data  = 32'h4332_2110;
    req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 5; t++) begin
      expv  = 4'b0001 << (t % 4);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (req_ready !== 4'b0000) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      tests++; if (!found) begin fails++; $display("FAIL rr_wait_%0d: got no req_ready want %b", t, expv); end
      tests++; if (req_ready !== expv) begin fails++; $display("FAIL rr_ready_%0d: got %b want %b", t, req_ready, expv); end
      tests++; if (arb_busy !== 1'b0) begin fails++; $display("FAIL rr_idle_%0d: got arb_busy %b want 0", t, arb_busy); end
      tick();
      tests++; if (grant_id !== 2'(t % 4)) begin fails++; $display("FAIL rr_grant_%0d: got %0d want %0d", t, grant_id, t % 4); end
      tests++; if (tx_data !== bytes[t % 4]) begin fails++; $display("FAIL rr_data_%0d: got %h want %h", t, tx_data, bytes[t % 4]); end
      $display("[TB] rr transfer %0d grant %0d data %h", t, grant_id, tx_data);
    end
    req_valid = 4'b0000;
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rr_idle_end: got busy want idle"); end
  endtask

  task automatic test_busy_block();
    bit blocked_ok = 1'b1, ok;
    apply_reset();
    busy_len   = 3;
    req_data   = 32'h4433_5A11;
    busy_force = 1'b1;
    busy_val   = 1'b1;
    tick();
    req_valid = 4'b1010;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (req_ready !== 4'b0000 || arb_busy) blocked_ok = 1'b0;
      tick();
    end
    tests++; if (!blocked_ok) begin fails++; $display("FAIL busy_block: got req_ready %b want 0000 while tx_busy", req_ready); end
    busy_val = 1'b0;
    @(negedge clk);
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL busy_release_ready: got %b want 0010", req_ready); end
    busy_force = 1'b0;
    tick();
    req_valid = 4'b0000;
    tests++; if (grant_id !== 2'd1) begin fails++; $display("FAIL busy_release_grant: got %0d want 1", grant_id); end
    tests++; if (tx_data !== 8'h5A) begin fails++; $display("FAIL busy_release_data: got %h want 5a", tx_data); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL busy_idle_end: got busy want idle"); end
    $display("[TB] test_busy_block done");
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0, ok;
    busy_len  = 20;
    req_data  = 32'h4433_2211;
    req_valid = 4'b0100;
    #1;
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_busy) begin
        seen = 1'b1;
        break;
      end
    end
    tests++; if (!seen) begin fails++; $display("FAIL rmid_busy: got no tx_busy want busy"); end
    tick();
    req_valid = 4'b1111;
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rmid_req_ready: got %b want 0000", req_ready); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rmid_tx_start: got %b want 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rmid_tx_data: got %h want 00", tx_data); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rmid_grant_id: got %0d want 0", grant_id); end
    tests++; if (arb_busy !== 1'b0) begin fails++; $display("FAIL rmid_arb_busy: got %b want 0", arb_busy); end
    tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL rmid_err_timeout: got %b want 0", err_timeout); end
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rmid_first_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rmid_first_grant: got %0d want 0", grant_id); end
    tests++; if (tx_data !== 8'h11) begin fails++; $display("FAIL rmid_first_data: got %h want 11", tx_data); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rmid_idle_end: got busy want idle"); end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_drop();
    bit seen = 1'b0, found = 1'b0, ok;
    apply_reset();
    busy_len  = 6;
    req_data  = 32'hD3C2_B1A0;
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_busy) begin
        seen = 1'b1;
        break;
      end
    end
    tests++; if (!seen) begin fails++; $display("FAIL drop_busy: got no tx_busy want busy"); end
    req_valid = 4'b1100;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL drop_ready_wait: got %b want 0000", req_ready); end
    tick();
    req_valid = 4'b1000;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req_ready !== 4'b0000) begin
        found = 1'b1;
        break;
      end
    end
    tests++; if (!found || req_ready !== 4'b1000) begin fails++; $display("FAIL drop_ready: got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    tests++; if (grant_id !== 2'd3) begin fails++; $display("FAIL drop_grant: got %0d want 3", grant_id); end
    tests++; if (tx_data !== 8'hD3) begin fails++; $display("FAIL drop_data: got %h want d3", tx_data); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL drop_idle: got busy want idle"); end
    req_valid = 4'b1111;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL drop_ptr_wrap: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    wait_idle(ok);
    $display("[TB] test_drop done");
  endtask

  task automatic test_timeout();
    bit quiet_ok = 1'b1;
    apply_reset();
    busy_force = 1'b1;
    busy_val   = 1'b0;
    req_data   = 32'h4433_22E7;
    tick();
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = 4'b0000;
    tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL to_start: got %b want 1", tx_start); end
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (err_timeout || !arb_busy) quiet_ok = 1'b0;
    end
    tests++; if (!quiet_ok) begin fails++; $display("FAIL to_early: got early err/idle want wait 16 cycles"); end
    tick();
    tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL to_pulse: got %b want 1", err_timeout); end
    tests++; if (arb_busy !== 1'b0) begin fails++; $display("FAIL to_idle: got %b want 0", arb_busy); end
    tick();
    tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL to_pulse_width: got %b want 0", err_timeout); end
`else
    for (int k = 0; k < 40; k++) begin
      tick();
      if (err_timeout || !arb_busy) quiet_ok = 1'b0;
    end
    tests++; if (!quiet_ok) begin fails++; $display("FAIL to_disabled: got err/idle want indefinite wait"); end
    apply_reset();
`endif
    busy_force = 1'b0;
    tick();
    $display("[TB] test_timeout done");
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy_block();
    test_reset_mid();
    test_drop();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of byte requesters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 2048, SHALL set the watchdog limit in clk cycles (used only when UART_ARB_TIMEOUT_EN is defined).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_ready  output  NUM_REQ  per-requester accept strobe; at most one bit high.
REQ-008 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 tx_data  output  8  byte presented to the transmitter, stable from tx_start until the transfer completes.
REQ-010 tx_busy  input  1  transmitter busy flag.
REQ-011 grant_id  output  clog2(NUM_REQ)  index of the requester owning the current transfer.
REQ-012 arb_busy  output  1  high in every state except IDLE.
REQ-013 err_timeout  output  1  one-cycle watchdog pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE with tx_busy=0 and any req_valid set, req_ready SHALL be driven combinationally high for exactly one winner, selected round-robin.
REQ-016 Round-robin: the search SHALL start at pointer rr_ptr and wrap modulo NUM_REQ; rr_ptr SHALL be 0 after reset and SHALL become (winner+1) mod NUM_REQ on each accept.
REQ-017 An accept occurs when req_valid[i] and req_ready[i] are both high; on that edge the block SHALL latch tx_data, latch grant_id=i and enter ISSUE.
REQ-018 In IDLE with tx_busy=1, req_ready SHALL stay all-zero.
REQ-019 ISSUE SHALL last exactly one cycle with tx_start=1 (registered), then go to WAIT_BUSY; accept-to-tx_start latency is one cycle.
REQ-020 WAIT_BUSY SHALL go to WAIT_DONE when tx_busy=1 is sampled.
REQ-021 WAIT_DONE SHALL return to IDLE when tx_busy=0 is sampled; no new accept may occur in that same cycle.
REQ-022 Back-to-back transfers SHALL have a minimum spacing of one IDLE cycle between tx_busy falling and the next accept.
REQ-023 A requester deasserting req_valid before it is accepted SHALL lose its turn without error; rr_ptr SHALL not change.
REQ-024 req_ready SHALL be zero in ISSUE, WAIT_BUSY and WAIT_DONE.

Reset
REQ-025 Assertion of reset_n=0 SHALL immediately force IDLE, rr_ptr=0, tx_start=0, tx_data=0, grant_id=0, arb_busy=0, err_timeout=0, req_ready=0 and clear the watchdog counter, including mid-transfer.
REQ-026 Deassertion SHALL take effect on the first clk edge after reset_n rises; there is no reset synchroniser inside this block.

Configuration
REQ-027 With UART_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_BUSY and WAIT_DONE.
REQ-028 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE and pulse err_timeout for one cycle.
REQ-029 Without UART_ARB_TIMEOUT_EN, no counter SHALL be built, err_timeout SHALL be tied 0, and WAIT states SHALL wait indefinitely.

Structure
REQ-030 Package uart_arb_pkg SHALL hold the FSM state enum typedef and the default NUM_REQ and TIMEOUT_CYCLES constants.
REQ-031 The round-robin selector SHALL be a separate sub-module, rr_picker (inputs req, ptr; outputs one-hot grant and index, plus any).

Verification
REQ-032 Single request: req_valid=4'b0100, req_data[23:16]=8'hA5, tx_busy modelled 1 cycle after tx_start for 20 cycles -> req_ready=4'b0100 for one cycle, tx_start one cycle later, tx_data=8'hA5, grant_id=2, arb_busy falls after tx_busy falls.
REQ-033 All four requesters held valid for 4 transfers from reset -> grant order 0,1,2,3, and the 5th grant is 0.
REQ-034 tx_busy held high while requesters 1 and 3 are valid -> req_ready stays 0 until tx_busy=0 in IDLE, then requester 1 is granted.
REQ-035 reset_n pulsed low during WAIT_DONE -> all outputs are zero asynchronously; after release, requester 0 is granted first.
REQ-036 With UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16 and tx_busy stuck 0 after tx_start -> err_timeout pulses 16 cycles after entering WAIT_BUSY and the FSM returns to IDLE.
REQ-037 Requester 2 drops req_valid one cycle before its turn while requester 3 is valid -> requester 3 is granted and rr_ptr becomes 0.
